// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: divides clk_50 by a latched ratio and emits a burst of nbits SCLK periods
// with edge strobes. Optional SPI_SCLK_ODD_DUTY_EN advances the leading edge half a cycle for odd ratios.
module spi_sclk_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk_50,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [CNT_W-1:0] nbits,
  input  logic             start,
  input  logic             abort,
  output logic             sclk,
  output logic             busy,
  output logic             lead_stb,
  output logic             trail_stb,
  output logic             sample_stb,
  output logic             shift_stb,
  output logic             done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [DIV_W-1:0] ph_reg, ph_next;
  logic [CNT_W-1:0] bc_reg, bc_next;
  logic [DIV_W-1:0] div_l_reg, div_l_next;
  logic             cpol_l_reg, cpol_l_next;
  logic             cpha_l_reg, cpha_l_next;
  logic [CNT_W-1:0] nbits_l_reg, nbits_l_next;
  logic             sclk_reg, sclk_next;
  logic             lead_reg, lead_next;
  logic             trail_reg, trail_next;
  logic             done_reg, done_next;
  logic             sample_reg, sample_next;
  logic             shift_reg, shift_next;

  logic [DIV_W-1:0] half_len;
  logic [DIV_W-1:0] low_len;
  logic [DIV_W-1:0] ph_inc;
  logic [CNT_W:0]   bc_inc;
  logic             wrap;

  // Idle (cpol) phase takes the extra cycle of an odd ratio.
  assign half_len = div_l_reg >> 1;
  assign low_len  = div_l_reg - half_len;
  assign ph_inc   = ph_reg + DIV_W'(1);
  assign bc_inc   = {1'b0, bc_reg} + (CNT_W+1)'(1);
  assign wrap     = (ph_reg == div_l_reg - DIV_W'(1));

  always_comb begin
    state_next   = state_reg;
    ph_next      = ph_reg;
    bc_next      = bc_reg;
    div_l_next   = div_l_reg;
    cpol_l_next  = cpol_l_reg;
    cpha_l_next  = cpha_l_reg;
    nbits_l_next = nbits_l_reg;
    sclk_next    = cpol_l_reg;
    lead_next    = 1'b0;
    trail_next   = 1'b0;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !abort && (nbits != '0)) begin
          state_next   = RUN;
          ph_next      = '0;
          bc_next      = '0;
          div_l_next   = (div < DIV_W'(2)) ? DIV_W'(2) : div;
          cpol_l_next  = cpol;
          cpha_l_next  = cpha;
          nbits_l_next = nbits;
          sclk_next    = cpol;
        end
      end
      default: begin
        if (abort) begin
          state_next = IDLE;
        end else if (wrap) begin
          ph_next    = '0;
          bc_next    = bc_inc[CNT_W-1:0];
          trail_next = 1'b1;
          if (bc_inc == {1'b0, nbits_l_reg}) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else begin
          ph_next = ph_inc;
          if (ph_inc >= low_len) sclk_next = ~cpol_l_reg;
          if (ph_inc == low_len) lead_next = 1'b1;
        end
      end
    endcase
    sample_next = cpha_l_reg ? trail_next : lead_next;
    shift_next  = cpha_l_reg ? lead_next  : trail_next;
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_reg   <= IDLE;
      ph_reg      <= '0;
      bc_reg      <= '0;
      div_l_reg   <= DIV_W'(2);
      cpol_l_reg  <= 1'b0;
      cpha_l_reg  <= 1'b0;
      nbits_l_reg <= '0;
      sclk_reg    <= 1'b0;
      lead_reg    <= 1'b0;
      trail_reg   <= 1'b0;
      done_reg    <= 1'b0;
      sample_reg  <= 1'b0;
      shift_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ph_reg      <= ph_next;
      bc_reg      <= bc_next;
      div_l_reg   <= div_l_next;
      cpol_l_reg  <= cpol_l_next;
      cpha_l_reg  <= cpha_l_next;
      nbits_l_reg <= nbits_l_next;
      sclk_reg    <= sclk_next;
      lead_reg    <= lead_next;
      trail_reg   <= trail_next;
      done_reg    <= done_next;
      sample_reg  <= sample_next;
      shift_reg   <= shift_next;
    end
  end

`ifdef SPI_SCLK_ODD_DUTY_EN
  logic early_reg;

  // Raised mid-cycle before a leading edge so the active level starts half a cycle early.
  always_ff @(negedge clk_50) begin
    if (rst) early_reg <= 1'b0;
    else     early_reg <= lead_next & div_l_reg[0];
  end

  assign sclk = (early_reg && state_reg == RUN) ? ~cpol_l_reg : sclk_reg;
`else
  assign sclk = sclk_reg;
`endif

  assign busy       = (state_reg == RUN);
  assign lead_stb   = lead_reg;
  assign trail_stb  = trail_reg;
  assign sample_stb = sample_reg;
  assign shift_stb  = shift_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: table of bursts checked cycle by cycle against a queued expected trace,
// plus hand sequences for reset, ignored starts, abort and mid-burst reset.
module tb_spi_sclk_gen;

  logic       clk_50 = 1'b0;
  logic       rst;
  logic [7:0] div;
  logic       cpol;
  logic       cpha;
  logic [5:0] nbits;
  logic       start;
  logic       abort;
  logic       sclk, busy, lead_stb, trail_stb, sample_stb, shift_stb, done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int div;
    bit cpol;
    bit cpha;
    int nbits;
    int done_ofs;  // done cycle relative to the start cycle
    int lead_ofs;  // leading edge position within a period (L)
  } vec_t;

  typedef struct packed {
    logic sclk, busy, lead, trail, sample, shift, done;
  } obs_t;

  obs_t exp_q[$];
  vec_t tbl[7];

  spi_sclk_gen dut (
    .clk_50    (clk_50),
    .rst       (rst),
    .div       (div),
    .cpol      (cpol),
    .cpha      (cpha),
    .nbits     (nbits),
    .start     (start),
    .abort     (abort),
    .sclk      (sclk),
    .busy      (busy),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb),
    .sample_stb(sample_stb),
    .shift_stb (shift_stb),
    .done      (done)
  );

  always #10 clk_50 = ~clk_50;

  function automatic obs_t observe();
    obs_t o;
    o = {sclk, busy, lead_stb, trail_stb, sample_stb, shift_stb, done};
    return o;
  endfunction

  task automatic step();
    @(posedge clk_50);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic drive(input vec_t v);
    div   = 8'(v.div);
    cpol  = v.cpol;
    cpha  = v.cpha;
    nbits = 6'(v.nbits);
  endtask

  task automatic scramble();
    div   = 8'($urandom_range(0, 255));
    cpol  = 1'($urandom_range(0, 1));
    cpha  = 1'($urandom_range(0, 1));
    nbits = 6'($urandom_range(0, 63));
  endtask

  // Expected trace for cycles T+1 .. T+done_ofs, built from the burst timing formulas.
  task automatic push_burst(input vec_t v);
    int   dl, p;
    obs_t e;
    dl = (v.div < 2) ? 2 : v.div;
    for (int c = 0; c < v.done_ofs; c++) begin
      if (c == v.done_ofs - 1) begin
        e = {v.cpol, 1'b0, 1'b0, 1'b1, v.cpha, ~v.cpha, 1'b1};
      end else begin
        p        = c % dl;
        e.sclk   = (p >= v.lead_ofs) ? ~v.cpol : v.cpol;
        e.busy   = 1'b1;
        e.lead   = (p == v.lead_ofs);
        e.trail  = (p == 0) && (c > 0);
        e.sample = v.cpha ? e.trail : e.lead;
        e.shift  = v.cpha ? e.lead : e.trail;
        e.done   = 1'b0;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic run_burst(input int idx, input int extra);
    vec_t v;
    obs_t e, a;
    int   nl, nt, left, cyc;
    v = tbl[idx];
    left = extra;
    drive(v);
    start = 1'b1;
    push_burst(v);
    nl = 0; nt = 0; cyc = 0;
    while (exp_q.size() > 0) begin
      step();
      start = 1'b0;
      scramble();
      e = exp_q.pop_front();
      a = observe();
      cyc++;
      n_cmp++;
      if (a != e) begin
        n_bad++;
        $display("FAIL burst%0d cyc%0d: got %07b expected %07b (sclk busy lead trail sample shift done)",
                 idx, cyc, a, e);
      end
      nl += int'(a.lead);
      nt += int'(a.trail);
      if (e.done) begin
        chk($sformatf("burst%0d lead_count", idx), nl, v.nbits);
        chk($sformatf("burst%0d trail_count", idx), nt, v.nbits);
        nl = 0; nt = 0; cyc = 0;
        if (left > 0) begin
          left--;
          drive(v);
          start = 1'b1;
          push_burst(v);
        end
      end
    end
  endtask

  initial begin
    // div, cpol, cpha, nbits, done_ofs, L
    tbl[0] = '{5, 1'b0, 1'b0, 8, 41, 3};
    tbl[1] = '{4, 1'b1, 1'b1, 1, 5, 2};
    tbl[2] = '{0, 1'b0, 1'b1, 3, 7, 1};
    tbl[3] = '{1, 1'b1, 1'b0, 2, 5, 1};
    tbl[4] = '{7, 1'b0, 1'b1, 3, 22, 4};
    tbl[5] = '{6, 1'b1, 1'b0, 2, 13, 3};
    tbl[6] = '{2, 1'b0, 1'b0, 63, 127, 1};

    rst = 1'b1; div = 8'd5; cpol = 1'b1; cpha = 1'b0; nbits = 6'd8; start = 1'b0; abort = 1'b0;
    step(); step();
    chk("reset_outputs", int'(observe()), 0);
    rst = 1'b0;

    step();
    chk("idle_sclk_latched_cpol", int'(sclk), 0);

    nbits = 6'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("start_nbits0_ignored", int'(busy), 0);

    nbits = 6'd4; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start_with_abort_dropped", int'(busy), 0);
    step();

    for (int i = 0; i < 7; i++) run_burst(i, 0);

    // Second burst started in the done cycle of the first.
    run_burst(5, 1);

    // Abort during bit 2 of an 8-bit burst.
    drive(tbl[0]); cpol = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 11; i++) step();
    chk("abort_pre_busy", int'(busy), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_sclk", int'(sclk), 1);
    chk("abort_strobes", int'({lead_stb, trail_stb, sample_stb, shift_stb, done}), 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_done", int'({done, busy}), 0);
    end
    nbits = 6'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("post_abort_nbits0_ignored", int'(busy), 0);

    // Reset in the middle of a cpol=1 burst.
    drive(tbl[0]); cpol = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("pre_rst_sclk", int'(sclk), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_outputs", int'(observe()), 0);
    step();
    chk("after_rst_idle", int'({busy, done}), 0);
    run_burst(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
